// File: rtl/mux_lut_pkg.sv
// rtl/mux_lut_pkg.sv - truth-table type and named two-input function encodings
// Truth-table bit index is {a_bit, b_bit}.
package mux_lut_pkg;
  typedef logic [3:0] lut_t;

  localparam lut_t LUT_AND    = 4'b1000;
  localparam lut_t LUT_OR     = 4'b1110;
  localparam lut_t LUT_XOR    = 4'b0110;
  localparam lut_t LUT_NAND   = 4'b0111;
  localparam lut_t LUT_NOR    = 4'b0001;
  localparam lut_t LUT_XNOR   = 4'b1001;
  localparam lut_t LUT_PASS_A = 4'b1100;
endpackage

// File: rtl/mux_lut_unit_mux2_vec.sv
// rtl/mux_lut_unit_mux2_vec.sv - W-bit bitwise 2:1 multiplexer with per-bit select
module mux2_vec #(
  parameter int W = 8
) (
  input  logic [W-1:0] sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  always_comb begin
    for (int i = 0; i < W; i++) begin
      y[i] = sel[i] ? d1[i] : d0[i];
    end
  end
endmodule

// File: rtl/mux_lut_unit.sv
// rtl/mux_lut_unit.sv - two-stage elastic bitwise LUT unit built from mux2_vec
// Optional transfer counter enabled by MUX_LUT_COUNT_EN.
module mux_lut_unit
  import mux_lut_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter lut_t LUT_RESET = LUT_OR
`ifdef MUX_LUT_COUNT_EN
  , parameter int COUNT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_lut,
  output logic [3:0]       lut,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
`ifdef MUX_LUT_COUNT_EN
  , output logic [COUNT_W-1:0] xfer_count
`endif
);
  lut_t             lut_q, lut_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] m0_q, m0_d, m1_q, m1_d, a_q, a_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] m0_w, m1_w, o_w;
  logic             s1_adv, s2_adv;

  // Level 1 folds b into the table rows using the lut value live at acceptance.
  mux2_vec #(.W(WIDTH)) u_m0 (
    .sel(b), .d0({WIDTH{lut_q[0]}}), .d1({WIDTH{lut_q[1]}}), .y(m0_w)
  );
  mux2_vec #(.W(WIDTH)) u_m1 (
    .sel(b), .d0({WIDTH{lut_q[2]}}), .d1({WIDTH{lut_q[3]}}), .y(m1_w)
  );
  mux2_vec #(.W(WIDTH)) u_o (
    .sel(a_q), .d0(m0_q), .d1(m1_q), .y(o_w)
  );

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    lut_d      = cfg_we ? lut_t'(cfg_lut) : lut_q;
    s1_valid_d = s1_valid_q;
    m0_d       = m0_q;
    m1_d       = m1_q;
    a_d        = a_q;
    s2_valid_d = s2_valid_q;
    o_d        = o_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        m0_d = m0_w;
        m1_d = m1_w;
        a_d  = a;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) o_d = o_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q      <= LUT_RESET;
      s1_valid_q <= 1'b0;
      m0_q       <= '0;
      m1_q       <= '0;
      a_q        <= '0;
      s2_valid_q <= 1'b0;
      o_q        <= '0;
    end else begin
      lut_q      <= lut_d;
      s1_valid_q <= s1_valid_d;
      m0_q       <= m0_d;
      m1_q       <= m1_d;
      a_q        <= a_d;
      s2_valid_q <= s2_valid_d;
      o_q        <= o_d;
    end
  end

  assign lut       = lut_q;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign o         = o_q;

`ifdef MUX_LUT_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready) cnt_d = cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_mux_lut_unit.sv
// tb/tb_mux_lut_unit.sv - table-driven scoreboard bench for mux_lut_unit
// Counter wrap test runs only when MUX_LUT_COUNT_EN is defined.
module tb_mux_lut_unit;
  import mux_lut_pkg::*;

  logic       clk = 0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_lut;
  logic [3:0] lut;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, o;
`ifdef MUX_LUT_COUNT_EN
  logic [3:0] xfer_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mux_lut_unit #(
    .WIDTH(8), .LUT_RESET(4'b1110)
`ifdef MUX_LUT_COUNT_EN
    , .COUNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut), .lut(lut),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .o(o)
`ifdef MUX_LUT_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  typedef struct {
    logic [3:0] l;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [7:0] model(input logic [3:0] l, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = l[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_lut(input logic [3:0] v);
    cfg_we = 1; cfg_lut = v;
    @(posedge clk); #1;
    cfg_we = 0;
    check("lut_write", {28'd0, lut}, {28'd0, v});
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] texp);
    bit done = 0;
    a = ta; b = tb_; in_valid = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(texp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] bp_a[3];
    logic [7:0] bp_b[3];
    int acc;
    int seen;

    tbl[0] = '{LUT_OR,     8'h0F, 8'h33, 8'h3F};
    tbl[1] = '{LUT_AND,    8'hA5, 8'h3C, 8'h24};
    tbl[2] = '{LUT_XOR,    8'hA5, 8'h3C, 8'h99};
    tbl[3] = '{LUT_NAND,   8'hA5, 8'h3C, 8'hDB};
    tbl[4] = '{LUT_NOR,    8'hA5, 8'h3C, 8'h42};
    tbl[5] = '{LUT_XNOR,   8'hA5, 8'h3C, 8'h66};
    tbl[6] = '{LUT_PASS_A, 8'hA5, 8'h3C, 8'hA5};
    bp_a = '{8'h12, 8'h80, 8'hC3};
    bp_b = '{8'h21, 8'h05, 8'h3C};

    rst_n = 0; cfg_we = 0; cfg_lut = 0; in_valid = 0; a = 0; b = 0; out_ready = 1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {24'd0, o}, 32'hFFFF_FFFF);
          end else begin
            check("scoreboard_o", {24'd0, o}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_o", {24'd0, o}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_lut", {28'd0, lut}, {28'd0, LUT_OR});
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Latency: two edges from acceptance to out_valid.
    send(8'h0F, 8'h33, 8'h3F);
    check("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge2_o", {24'd0, o}, 32'h3F);
    @(posedge clk); #1;
    check("lat_pulse_low", {31'd0, out_valid}, 32'd0);
    wait_drain();

    for (int i = 0; i < 7; i++) begin
      set_lut(tbl[i].l);
      send(tbl[i].va, tbl[i].vb, tbl[i].exp);
      wait_drain();
    end

    // Backpressure: three offered, two fit.
    set_lut(LUT_OR);
    out_ready = 0; acc = 0;
    in_valid = 1; a = bp_a[0]; b = bp_b[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready && acc < 3) begin
        exp_q.push_back(model(LUT_OR, bp_a[acc], bp_b[acc]));
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) begin a = bp_a[acc]; b = bp_b[acc]; end
    end
    check("bp_accepted", acc, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_o_head", {24'd0, o}, {24'd0, model(LUT_OR, bp_a[0], bp_b[0])});
    held = o;
    @(posedge clk); #1;
    check("bp_o_stable", {24'd0, o}, {24'd0, held});
    out_ready = 1; #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 20 && acc < 3; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(LUT_OR, bp_a[acc], bp_b[acc]));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("bp_all_accepted", acc, 32'd3);
    wait_drain();

    // Reprogram in the same cycle as an accepted transfer.
    in_valid = 1; a = 8'hFF; b = 8'h0F; cfg_we = 1; cfg_lut = LUT_XOR;
    @(negedge clk);
    check("reprog_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    cfg_we = 0;
    check("reprog_lut", {28'd0, lut}, {28'd0, LUT_XOR});
    @(negedge clk);
    exp_q.push_back(8'hF0);
    @(posedge clk); #1;
    in_valid = 0;
    wait_drain();

    // Async reset with both stages full.
    set_lut(LUT_AND);
    out_ready = 0;
    send(8'h11, 8'h22, 8'h00);
    send(8'h33, 8'h44, 8'h00);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2; rst_n = 0; #1;
    exp_q.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_o", {24'd0, o}, 32'd0);
    check("arst_lut", {28'd0, lut}, {28'd0, LUT_OR});
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1; out_ready = 1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", seen, 32'd0);

`ifdef MUX_LUT_COUNT_EN
    out_ready = 0;
    send(8'h01, 8'h02, model(LUT_OR, 8'h01, 8'h02));
    send(8'h03, 8'h04, model(LUT_OR, 8'h03, 8'h04));
    repeat (3) @(posedge clk);
    #1;
    check("cnt_stalled", {28'd0, xfer_count}, 32'd0);
    out_ready = 1;
    for (int i = 2; i < 17; i++) begin
      send(8'(i), 8'(i * 3), model(LUT_OR, 8'(i), 8'(i * 3)));
    end
    wait_drain();
    check("cnt_wrap", {28'd0, xfer_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
